// File: rtl/rtc_timekeeper_if.sv
// Bus bundle between the RTC timekeeper and its controller/display side.
// The master drives run/load/adjust controls; the slave returns the registered time.
interface rtc_timekeeper_if;
  logic       en;
  logic       load;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       inc_min;
  logic       inc_hour;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick_1hz;
  logic       set_err;

  modport master (
    output en, load, set_hour, set_min, set_sec, inc_min, inc_hour,
    input  sec, min, hour, tick_1hz, set_err
  );

  modport slave (
    input  en, load, set_hour, set_min, set_sec, inc_min, inc_hour,
    output sec, min, hour, tick_1hz, set_err
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// 24-hour real-time clock: 1 Hz prescaler, HH:MM:SS counters, validated load
// and minute/hour adjust buttons. All outputs are registered.
module rtc_timekeeper #(
  parameter int TICK_DIV = 100_000_000
) (
  input logic            clk,
  input logic            rst,
  rtc_timekeeper_if.slave bus
);

  localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRES_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pres;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [4:0]    hour_q;
  logic          tick_q;
  logic          err_q;
  logic          pending;
  logic          inc_min_q;
  logic          inc_hour_q;

  logic raw_tick;
  logic set_legal;
  logic load_ok;
  logic edge_min;
  logic edge_hour;

  always_comb begin
    raw_tick  = bus.en && (pres == PRES_MAX);
    set_legal = (bus.set_hour < 5'd24) && (bus.set_min < 6'd60) && (bus.set_sec < 6'd60);
    load_ok   = bus.load && set_legal;
    edge_min  = bus.inc_min  && !inc_min_q;
    edge_hour = bus.inc_hour && !inc_hour_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pres       <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      pending    <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
    end else begin
      tick_q     <= 1'b0;
      err_q      <= bus.load && !set_legal;
      inc_min_q  <= bus.inc_min;
      inc_hour_q <= bus.inc_hour;

      if (load_ok) begin
        // A raw tick in this cycle is intentionally dropped: the loaded time
        // defines a fresh second boundary.
        hour_q  <= bus.set_hour;
        min_q   <= bus.set_min;
        sec_q   <= bus.set_sec;
        pres    <= '0;
        pending <= 1'b0;
      end else begin
        if (bus.en)
          pres <= (pres == PRES_MAX) ? '0 : pres + 1'b1;

        if (edge_min || edge_hour) begin
          if (edge_min)
            min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          if (edge_hour)
            hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          // Defer the second so it is not lost under the adjust.
          if (raw_tick)
            pending <= 1'b1;
        end else if (raw_tick || pending) begin
          pending <= 1'b0;
          tick_q  <= 1'b1;
          if (sec_q == 6'd59) begin
            sec_q <= 6'd0;
            if (min_q == 6'd59) begin
              min_q  <= 6'd0;
              hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end
      end
    end
  end

  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.tick_1hz = tick_q;
  assign bus.set_err  = err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper (TICK_DIV = 4): a seconds-of-day reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rtc_timekeeper;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  rtc_timekeeper_if bus();

  rtc_timekeeper #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  // Reference model: time held as seconds-of-day, phase as an integer.
  int m_t = 0;
  int m_phase = 0;
  bit m_pend = 0;
  bit m_pmin = 0;
  bit m_phour = 0;
  bit m_tick = 0;
  bit m_err = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    bit raw, legal, em, eh;
    int h, m, s;
    if (rst) begin
      m_t = 0; m_phase = 0; m_pend = 0; m_pmin = 0; m_phour = 0;
      m_tick = 0; m_err = 0; m_valid = 1;
    end else begin
      raw   = bus.en && (m_phase == TD - 1);
      legal = (int'(bus.set_hour) < 24) && (int'(bus.set_min) < 60) && (int'(bus.set_sec) < 60);
      em    = bus.inc_min && !m_pmin;
      eh    = bus.inc_hour && !m_phour;
      m_err  = bus.load && !legal;
      m_tick = 0;
      if (bus.load && legal) begin
        m_t = hms(int'(bus.set_hour), int'(bus.set_min), int'(bus.set_sec));
        m_phase = 0;
        m_pend = 0;
      end else begin
        if (bus.en) m_phase = (m_phase + 1) % TD;
        if (em || eh) begin
          h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
          if (em) m = (m + 1) % 60;
          if (eh) h = (h + 1) % 24;
          m_t = hms(h, m, s);
          if (raw) m_pend = 1;
        end else if (raw || m_pend) begin
          m_t = (m_t + 1) % 86400;
          m_pend = 0;
          m_tick = 1;
        end
      end
      m_pmin  = bus.inc_min;
      m_phour = bus.inc_hour;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sec",  int'(bus.sec),      m_t % 60);
      chk("model_min",  int'(bus.min),      (m_t / 60) % 60);
      chk("model_hour", int'(bus.hour),     m_t / 3600);
      chk("model_tick", int'(bus.tick_1hz), int'(m_tick));
      chk("model_err",  int'(bus.set_err),  int'(m_err));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_hour"}, int'(bus.hour), h);
    chk({name, "_min"},  int'(bus.min),  m);
    chk({name, "_sec"},  int'(bus.sec),  s);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bus.load = 1'b1;
    bus.set_hour = 5'(h);
    bus.set_min  = 6'(m);
    bus.set_sec  = 6'(s);
    step(1);
    bus.load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.set_hour = '0; bus.set_min = '0;
    bus.set_sec = '0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
    rst = 1'b1;
    step(1);
    chk_time("reset", 0, 0, 0);
    chk("reset_tick", int'(bus.tick_1hz), 0);
    chk("reset_err",  int'(bus.set_err), 0);

    // Free run: one tick every 4th cycle, 00:01:00 after 240 cycles.
    rst = 1'b0;
    bus.en = 1'b1;
    step(3);
    chk("run_no_tick_yet", int'(bus.tick_1hz), 0);
    step(1);
    chk("run_first_tick", int'(bus.tick_1hz), 1);
    chk("run_first_sec",  int'(bus.sec), 1);
    step(236);
    chk_time("run_240", 0, 1, 0);
    chk("model_pin_240", m_t, hms(0, 1, 0));

    // Midnight rollover.
    do_load(23, 59, 58);
    chk_time("load_2359", 23, 59, 58);
    step(4);
    chk_time("roll_a", 23, 59, 59);
    chk("roll_a_tick", int'(bus.tick_1hz), 1);
    step(4);
    chk_time("roll_b", 0, 0, 0);
    chk("roll_b_tick", int'(bus.tick_1hz), 1);

    // Illegal loads: error pulse, time and prescaler untouched.
    do_load(24, 0, 0);
    chk("bad_hour_err", int'(bus.set_err), 1);
    chk_time("bad_hour", 0, 0, 0);
    step(1);
    chk("bad_err_pulse", int'(bus.set_err), 0);
    step(2);
    chk_time("bad_prescaler", 0, 0, 1);
    chk("bad_prescaler_tick", int'(bus.tick_1hz), 1);
    do_load(5, 60, 0);
    chk("bad_min_err", int'(bus.set_err), 1);
    chk_time("bad_min", 0, 0, 1);

    // Adjust buttons with the prescaler frozen.
    bus.en = 1'b0;
    do_load(10, 59, 30);
    bus.inc_min = 1'b1;
    step(1);
    chk_time("inc_min_wrap", 10, 0, 30);
    step(2);
    chk_time("inc_min_level", 10, 0, 30);
    bus.inc_min = 1'b0;
    do_load(23, 15, 7);
    bus.inc_hour = 1'b1;
    step(1);
    chk_time("inc_hour_wrap", 0, 15, 7);
    bus.inc_hour = 1'b0;
    step(1);
    bus.inc_min = 1'b1;
    bus.inc_hour = 1'b1;
    step(1);
    chk_time("inc_both", 1, 16, 7);
    bus.inc_min = 1'b0;
    bus.inc_hour = 1'b0;
    step(1);

    // Adjust edge on a raw tick: second deferred by one cycle.
    bus.en = 1'b1;
    do_load(12, 30, 45);
    step(3);
    chk_time("pend_pre", 12, 30, 45);
    bus.inc_min = 1'b1;
    step(1);
    chk_time("pend_adjust", 12, 31, 45);
    chk("pend_adjust_tick", int'(bus.tick_1hz), 0);
    step(1);
    chk_time("pend_apply", 12, 31, 46);
    chk("pend_apply_tick", int'(bus.tick_1hz), 1);
    bus.inc_min = 1'b0;

    // Freeze, then reset mid-count.
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("hold_tick", int'(bus.tick_1hz), 0);
    end
    chk_time("hold", 12, 31, 46);
    bus.en = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    chk_time("mid_reset", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("post_rst_quiet", int'(bus.tick_1hz), 0);
    end
    step(1);
    chk("post_rst_tick", int'(bus.tick_1hz), 1);
    chk_time("post_rst", 0, 0, 1);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
